// File: rtl/victim_pkg.sv
// Shared types and defaults for the victim buffer: geometry defaults,
// the per-entry record and the writeback FSM encoding.
package victim_pkg;

  localparam int S_OFFSET = 5;
  localparam int S_INDEX  = 4;
  localparam int LA_W     = 32 - S_OFFSET;
  localparam int LINE_W   = 256;

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [LA_W-1:0]   line;
    logic [LINE_W-1:0] data;
  } vb_entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WB   = 1'b1
  } vb_state_t;

endpackage

// File: rtl/victim_compare.sv
// Per-entry address comparator: matches one stored line address against
// both the lookup probe and the incoming eviction.
module victim_compare #(
  parameter int la_w = 27
) (
  input  logic            valid,
  input  logic [la_w-1:0] entry_line,
  input  logic [la_w-1:0] lookup_line,
  input  logic [la_w-1:0] evict_line,
  output logic            lookup_match,
  output logic            evict_match
);

  assign lookup_match = valid && (entry_line == lookup_line);
  assign evict_match  = valid && (entry_line == evict_line);

endmodule

// File: rtl/victim_buffer.sv
// Fully associative victim buffer sitting beside the L1.
// Accepts evicted lines, serves combinational lookups (with optional take
// to swap a line back), and writes back a dirty round-robin victim through
// a single writeback register when the buffer is full.
// Optional build macro VB_STATS_EN adds saturating take / writeback counters.
module victim_buffer
  import victim_pkg::*;
#(
  parameter int s_offset = S_OFFSET,
  parameter int s_index  = S_INDEX,
  parameter int vb_depth = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         evict_valid,
  output logic         evict_ready,
  input  logic [31:0]  evict_addr,
  input  logic [255:0] evict_data,
  input  logic         evict_dirty,
  input  logic [31:0]  lookup_addr,
  output logic         lookup_hit,
  output logic [255:0] lookup_data,
  output logic         lookup_dirty,
  input  logic         lookup_take,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic         pmem_resp
`ifdef VB_STATS_EN
  ,
  output logic [31:0]  vb_hits,
  output logic [31:0]  vb_wbs
`endif
);

  localparam int la_w = 32 - s_offset;
  localparam int rr_w = $clog2(vb_depth);

  if (vb_depth < 2 || vb_depth > 8 || (vb_depth & (vb_depth - 1)) != 0 ||
      s_offset + s_index > 31) begin : g_param_check
    $error("victim_buffer: unsupported parameter combination");
  end

  vb_entry_t           entries [vb_depth];
  vb_state_t           state, state_next;
  logic [rr_w-1:0]     rr;

  logic [la_w-1:0]     lookup_line, evict_line;
  logic [vb_depth-1:0] lookup_match, evict_match;
  logic [vb_depth-1:0] slot_free, evict_match_live;
  logic                take_fire, any_free, any_match, rr_dirty;
  logic [rr_w-1:0]     free_idx, match_idx, ins_idx;
  logic                do_insert, wb_start;
  logic                unused_offset_bits;

  assign lookup_line = lookup_addr[31:s_offset];
  assign evict_line  = evict_addr[31:s_offset];
  assign unused_offset_bits = ^{lookup_addr[s_offset-1:0], evict_addr[s_offset-1:0]};

  for (genvar i = 0; i < vb_depth; i++) begin : g_cmp
    victim_compare #(.la_w(la_w)) u_cmp (
      .valid        (entries[i].valid),
      .entry_line   (entries[i].line),
      .lookup_line  (lookup_line),
      .evict_line   (evict_line),
      .lookup_match (lookup_match[i]),
      .evict_match  (evict_match[i])
    );
  end

  // Hit muxing plus free-slot / in-place-match selection. A slot being taken
  // this cycle is treated as free and no longer counts as an in-place target.
  always_comb begin
    lookup_hit       = |lookup_match;
    take_fire        = lookup_take && lookup_hit;
    lookup_data      = '0;
    lookup_dirty     = 1'b0;
    slot_free        = '0;
    evict_match_live = '0;
    free_idx         = '0;
    match_idx        = '0;
    for (int i = 0; i < vb_depth; i++) begin
      if (lookup_match[i]) begin
        lookup_data  = lookup_data | entries[i].data;
        lookup_dirty = lookup_dirty | entries[i].dirty;
      end
      slot_free[i]        = !entries[i].valid || (take_fire && lookup_match[i]);
      evict_match_live[i] = evict_match[i] && !(take_fire && lookup_match[i]);
    end
    for (int i = vb_depth - 1; i >= 0; i--) begin
      if (slot_free[i])        free_idx  = rr_w'(i);
      if (evict_match_live[i]) match_idx = rr_w'(i);
    end
    any_free  = |slot_free;
    any_match = |evict_match_live;
    rr_dirty  = entries[rr].dirty;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // FSM next state: leave IDLE only when the eviction needs a dirty victim written out.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (evict_valid && !any_free && !any_match && rr_dirty) state_next = ST_WB;
      ST_WB:   if (pmem_resp) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: accept/stall decision and writeback launch.
  always_comb begin
    evict_ready = 1'b0;
    wb_start    = 1'b0;
    case (state)
      ST_IDLE: begin
        evict_ready = any_free || any_match || !rr_dirty;
        wb_start    = evict_valid && !(any_free || any_match || !rr_dirty);
      end
      default: ;
    endcase
  end

  // Insert target: in-place merge beats lowest free slot beats round-robin victim.
  always_comb begin
    do_insert = evict_valid && evict_ready;
    if (any_match)     ins_idx = match_idx;
    else if (any_free) ins_idx = free_idx;
    else               ins_idx = rr;
  end

  // Entry storage: take clears, writeback launch invalidates the victim, insert writes last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < vb_depth; i++) entries[i] <= '0;
    end else begin
      for (int i = 0; i < vb_depth; i++) begin
        if (take_fire && lookup_match[i]) entries[i].valid <= 1'b0;
      end
      if (wb_start) entries[rr].valid <= 1'b0;
      if (do_insert) begin
        entries[ins_idx].valid <= 1'b1;
        entries[ins_idx].line  <= evict_line;
        entries[ins_idx].data  <= evict_data;
        entries[ins_idx].dirty <= any_match ? (entries[ins_idx].dirty | evict_dirty)
                                            : evict_dirty;
      end
    end
  end

  // Round-robin pointer moves only when a valid line is overwritten without writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    rr <= '0;
    else if (do_insert && !any_match && !any_free) rr <= rr + 1'b1;
  end

  // Writeback register: loaded from the victim on launch, held until memory responds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else if (wb_start) begin
      pmem_write   <= 1'b1;
      pmem_address <= {entries[rr].line, {s_offset{1'b0}}};
      pmem_wdata   <= entries[rr].data;
    end else if (state == ST_WB && pmem_resp) begin
      pmem_write   <= 1'b0;
    end
  end

`ifdef VB_STATS_EN
  // Saturating counts of swaps back to L1 and of completed writebacks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vb_hits <= '0;
      vb_wbs  <= '0;
    end else begin
      if (take_fire && vb_hits != '1)                 vb_hits <= vb_hits + 32'd1;
      if (state == ST_WB && pmem_resp && vb_wbs != '1) vb_wbs  <= vb_wbs + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_victim_buffer.sv
// Bench for victim_buffer: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against an array-based model.
module tb_victim_buffer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         evict_valid = 1'b0;
  logic         evict_ready;
  logic [31:0]  evict_addr = '0;
  logic [255:0] evict_data = '0;
  logic         evict_dirty = 1'b0;
  logic [31:0]  lookup_addr = '0;
  logic         lookup_hit;
  logic [255:0] lookup_data;
  logic         lookup_dirty;
  logic         lookup_take = 1'b0;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_resp = 1'b0;
`ifdef VB_STATS_EN
  logic [31:0]  vb_hits, vb_wbs;
`endif

  int checks = 0;
  int errors = 0;

  victim_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .evict_valid  (evict_valid),
    .evict_ready  (evict_ready),
    .evict_addr   (evict_addr),
    .evict_data   (evict_data),
    .evict_dirty  (evict_dirty),
    .lookup_addr  (lookup_addr),
    .lookup_hit   (lookup_hit),
    .lookup_data  (lookup_data),
    .lookup_dirty (lookup_dirty),
    .lookup_take  (lookup_take),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp)
`ifdef VB_STATS_EN
    ,
    .vb_hits      (vb_hits),
    .vb_wbs       (vb_wbs)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model: four slots, plain arrays ----------
  bit           mv   [4];
  bit           md   [4];
  logic [26:0]  ml   [4];
  logic [255:0] mdat [4];
  int           m_rr;
  bit           m_wb;
  logic [31:0]  m_wba;
  logic [255:0] m_wbd;
  int           m_tk, m_tgt, m_em, m_fr, c_h;
  bit           m_rdy;

  function automatic int m_hit(logic [31:0] a);
    for (int i = 0; i < 4; i++) if (mv[i] && ml[i] == a[31:5]) return i;
    return -1;
  endfunction

  function automatic int m_take();
    int h;
    h = m_hit(lookup_addr);
    return (lookup_take && h >= 0) ? h : -1;
  endfunction

  function automatic int m_match(int tk);
    for (int i = 0; i < 4; i++)
      if (i != tk && mv[i] && ml[i] == evict_addr[31:5]) return i;
    return -1;
  endfunction

  function automatic int m_free(int tk);
    for (int i = 0; i < 4; i++) if (!mv[i] || i == tk) return i;
    return -1;
  endfunction

  function automatic bit m_ready();
    int tk;
    if (m_wb) return 1'b0;
    tk = m_take();
    return (m_free(tk) >= 0) || (m_match(tk) >= 0) || !md[m_rr];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        mv[i] = 0; md[i] = 0; ml[i] = '0; mdat[i] = '0;
      end
      m_rr = 0; m_wb = 0; m_wba = '0; m_wbd = '0;
    end else begin
      m_tk  = m_take();
      m_rdy = m_ready();
      m_tgt = -1;
      if (m_wb) begin
        if (pmem_resp) m_wb = 0;
      end else if (evict_valid) begin
        if (m_rdy) begin
          m_em = m_match(m_tk);
          m_fr = m_free(m_tk);
          if (m_em >= 0) begin
            mdat[m_em] = evict_data;
            md[m_em]   = md[m_em] | evict_dirty;
            m_tgt      = m_em;
          end else begin
            if (m_fr >= 0) m_tgt = m_fr;
            else begin
              m_tgt = m_rr;
              m_rr  = (m_rr + 1) % 4;
            end
            mv[m_tgt] = 1; md[m_tgt] = evict_dirty;
            ml[m_tgt] = evict_addr[31:5]; mdat[m_tgt] = evict_data;
          end
        end else begin
          m_wba = {ml[m_rr], 5'b0};
          m_wbd = mdat[m_rr];
          mv[m_rr] = 0;
          m_wb = 1;
        end
      end
      if (m_tk >= 0 && m_tk != m_tgt) mv[m_tk] = 0;
    end
  end

  // Every-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    if (!rst) begin
      c_h = m_hit(lookup_addr);
      chk("m_lookup_hit",   lookup_hit,   c_h >= 0);
      chk("m_lookup_data",  lookup_data,  (c_h >= 0) ? mdat[c_h] : 256'h0);
      chk("m_lookup_dirty", lookup_dirty, (c_h >= 0) ? md[c_h] : 1'b0);
      chk("m_evict_ready",  evict_ready,  m_ready());
      chk("m_pmem_write",   pmem_write,   m_wb);
      chk("m_pmem_address", pmem_address, m_wba);
      chk("m_pmem_wdata",   pmem_wdata,   m_wbd);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [255:0] dat(int k);
    logic [31:0] w;
    w = 32'h5A5A_0000 ^ k;
    return {8{w}};
  endfunction

  function automatic logic [255:0] rnd256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic neg();
    @(negedge clk); #1;
  endtask

  task automatic idle_in();
    evict_valid = 0; evict_dirty = 0; evict_addr = '0; evict_data = '0;
    lookup_take = 0; pmem_resp = 0;
  endtask

  task automatic do_reset();
    rst = 1; idle_in(); cyc(); rst = 0;
  endtask

  task automatic put(logic [31:0] a, logic [255:0] d, bit dy);
    evict_valid = 1; evict_addr = a; evict_data = d; evict_dirty = dy;
    cyc();
    evict_valid = 0;
  endtask

  initial begin
    // reset, single clean insert, lookup with offset bits set
    do_reset();
    lookup_addr = 32'h0000_101C;
    neg();
    chk("rst_hit", lookup_hit, 1'b0);
    chk("rst_data", lookup_data, 256'h0);
    chk("rst_pmem_write", pmem_write, 1'b0);
    chk("rst_pmem_address", pmem_address, 32'h0);
    chk("rst_ready", evict_ready, 1'b1);
    put(32'h0000_1000, dat(1), 0);
    neg();
    chk("ins_hit", lookup_hit, 1'b1);
    chk("ins_data", lookup_data, dat(1));
    chk("ins_dirty", lookup_dirty, 1'b0);

    // same line clean then dirty merges into one entry
    put(32'h0000_2000, dat(2), 0);
    put(32'h0000_2004, dat(3), 1);
    lookup_addr = 32'h0000_2000;
    neg();
    chk("merge_hit", lookup_hit, 1'b1);
    chk("merge_dirty", lookup_dirty, 1'b1);
    chk("merge_data", lookup_data, dat(3));
    put(32'h0000_3000, dat(4), 0);
    put(32'h0000_4000, dat(5), 0);
    lookup_addr = 32'h0000_1000;
    neg();
    chk("merge_single_slot", lookup_hit, 1'b1);

    // four clean, fifth overwrites slot 0, rr advances and wraps
    do_reset();
    put(32'h0000_1000, dat(11), 0);
    put(32'h0000_2000, dat(12), 0);
    put(32'h0000_3000, dat(13), 0);
    put(32'h0000_4000, dat(14), 0);
    evict_valid = 1; evict_addr = 32'h0000_5000; evict_data = dat(15); evict_dirty = 0;
    neg();
    chk("clean_full_ready", evict_ready, 1'b1);
    cyc(); evict_valid = 0;
    lookup_addr = 32'h0000_1000;
    neg();
    chk("clean_victim_gone", lookup_hit, 1'b0);
    chk("clean_no_wb", pmem_write, 1'b0);
    put(32'h0000_6000, dat(16), 0);
    lookup_addr = 32'h0000_2000;
    neg();
    chk("rr_slot1_gone", lookup_hit, 1'b0);
    put(32'h0000_7000, dat(17), 0);
    put(32'h0000_8000, dat(18), 0);
    put(32'h0000_9000, dat(19), 0);
    lookup_addr = 32'h0000_5000;
    neg();
    chk("rr_wrap_slot0", lookup_hit, 1'b0);
    lookup_addr = 32'h0000_6000;
    neg();
    chk("rr_wrap_keep", lookup_hit, 1'b1);

    // four dirty, fifth forces writeback of the first line
    do_reset();
    put(32'h0000_1000, dat(21), 1);
    put(32'h0000_2000, dat(22), 1);
    put(32'h0000_3000, dat(23), 1);
    put(32'h0000_4000, dat(24), 1);
    evict_valid = 1; evict_addr = 32'h0000_5000; evict_data = dat(25); evict_dirty = 1;
    neg();
    chk("dirty_full_ready", evict_ready, 1'b0);
    cyc();
    lookup_addr = 32'h0000_1000;
    neg();
    chk("wb_write", pmem_write, 1'b1);
    chk("wb_address", pmem_address, 32'h0000_1000);
    chk("wb_data", pmem_wdata, dat(21));
    chk("wb_ready", evict_ready, 1'b0);
    chk("wb_victim_gone", lookup_hit, 1'b0);
    cyc();
    neg();
    chk("wb_hold_write", pmem_write, 1'b1);
    chk("wb_hold_ready", evict_ready, 1'b0);
    pmem_resp = 1;
    cyc();
    pmem_resp = 0;
    neg();
    chk("wb_done_write", pmem_write, 1'b0);
    chk("wb_done_ready", evict_ready, 1'b1);
    cyc();
    evict_valid = 0;
    lookup_addr = 32'h0000_5000;
    neg();
    chk("wb_after_insert", lookup_hit, 1'b1);
    chk("wb_after_data", lookup_data, dat(25));

    // take on slot 2 alongside an insert into a full dirty buffer
    do_reset();
    put(32'h0000_1000, dat(31), 1);
    put(32'h0000_2000, dat(32), 1);
    put(32'h0000_3000, dat(33), 1);
    put(32'h0000_4000, dat(34), 1);
    lookup_addr = 32'h0000_3000; lookup_take = 1;
    evict_valid = 1; evict_addr = 32'h0000_7000; evict_data = dat(37); evict_dirty = 1;
    neg();
    chk("take_ready", evict_ready, 1'b1);
    chk("take_hit", lookup_hit, 1'b1);
    cyc();
    lookup_take = 0; evict_valid = 0;
    neg();
    chk("take_no_wb", pmem_write, 1'b0);
    chk("take_removed", lookup_hit, 1'b0);
    lookup_addr = 32'h0000_7000;
    neg();
    chk("take_new_line", lookup_hit, 1'b1);

    // reset during a writeback drops it immediately
    put(32'h0000_8000, dat(38), 1);
    neg();
    chk("rstwb_write", pmem_write, 1'b1);
    chk("rstwb_address", pmem_address, 32'h0000_1000);
    rst = 1;
    #1;
    chk("rstwb_write_cleared", pmem_write, 1'b0);
    chk("rstwb_addr_cleared", pmem_address, 32'h0);
    idle_in();
    cyc();
    rst = 0;
    neg();
    chk("rstwb_lookup_gone", lookup_hit, 1'b0);

    // randomized traffic, model checks every cycle
    for (int n = 0; n < 4000; n++) begin
      cyc();
      rst         = ($urandom_range(0, 599) == 0);
      evict_valid = ($urandom_range(0, 1) == 1);
      evict_addr  = (32'($urandom_range(1, 6)) << 12) | 32'($urandom_range(0, 31));
      evict_data  = rnd256();
      evict_dirty = ($urandom_range(0, 1) == 1);
      lookup_addr = (32'($urandom_range(1, 6)) << 12) | 32'($urandom_range(0, 31));
      lookup_take = ($urandom_range(0, 3) == 0);
      pmem_resp   = ($urandom_range(0, 2) == 0);
    end
    cyc();
    rst = 0;
    idle_in();
    neg();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
